// File: rtl/seq_sub_divider.sv
// Multi-cycle unsigned restoring divider using trial subtraction (a + ~b + 1).
// One quotient bit per clock, start/done handshake, registered results.
module seq_sub_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    logic [N:0]    r;
    logic [N-1:0]  q;
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;

    logic [N:0]    rs;
    logic [N:0]    diff;
    logic [N:0]    r_next;
    logic [N-1:0]  q_next;
    logic          carry;
    logic          nb;

    assign rs = {r[N-1:0], q[N-1]};
    assign {carry, diff} = {1'b0, rs} + {1'b0, ~{1'b0, d}} + (N+2)'(1);
    // A bit shifted out of R's top means the shifted value exceeds any D.
    assign nb = carry | r[N];
    assign r_next = nb ? diff : rs;
    assign q_next = {q[N-2:0], nb};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            q     <= dividend;
                            d     <= divisor;
                            r     <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    q   <= q_next;
                    r   <= r_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N-1)) begin
                        quotient    <= q_next;
                        remainder   <= r_next[N-1:0];
                        div_by_zero <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_sub_divider.sv
// Scoreboard bench for seq_sub_divider: directed vectors plus a random
// back-to-back run checked against a reference quotient/remainder model.
module tb_seq_sub_divider;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    seq_sub_divider #(.N(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input bit ok,
                       input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals done.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1'b0, {32'd0, quotient}, 64'd0);
            end else begin
                exp_t e;
                logic [63:0] recon;
                e = sb.pop_front();
                chk("result_q", quotient == e.q, {32'd0, quotient}, {32'd0, e.q});
                chk("result_r", remainder == e.r, {32'd0, remainder}, {32'd0, e.r});
                chk("result_dz", div_by_zero == e.dz, {63'd0, div_by_zero}, {63'd0, e.dz});
                if (e.b != 0) begin
                    recon = 64'(quotient) * 64'(e.b) + 64'(remainder);
                    chk("invariant", recon == 64'(e.a) && remainder < e.b,
                        recon, 64'(e.a));
                end
            end
        end
    end

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while ((busy || done) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("idle_wait", 1'b0, 64'd1, 64'd0);
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
            e.dz = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dz = 1'b0;
        end
        sb.push_back(e);
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called #1 after the accepting edge; counts edges until done rises.
    task automatic finish_op(input int exp_lat, input int exp_busy, input bit strict);
        int lat;
        int busy_n;
        lat = 0;
        busy_n = 0;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (strict) begin
            chk("latency", lat == exp_lat, 64'(lat), 64'(exp_lat));
            chk("busy_cycles", busy_n == exp_busy, 64'(busy_n), 64'(exp_busy));
            chk("busy_at_done", busy == 1'b0, {63'd0, busy}, 64'd0);
        end else if (lat >= 100) begin
            chk("done_timeout", 1'b0, 64'(lat), 64'(exp_lat));
        end
        @(posedge clk);
        #1;
        if (strict) chk("done_one_cycle", done == 1'b0, {63'd0, done}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int dcount;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        #12;
        chk("rst_busy", busy == 1'b0, {63'd0, busy}, 64'd0);
        chk("rst_done", done == 1'b0, {63'd0, done}, 64'd0);
        chk("rst_q", quotient == '0, {32'd0, quotient}, 64'd0);
        chk("rst_r", remainder == '0, {32'd0, remainder}, 64'd0);
        chk("rst_dz", div_by_zero == 1'b0, {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(32'd100, 32'd7);
        chk("busy_after_start", busy == 1'b1, {63'd0, busy}, 64'd1);
        finish_op(N, N, 1'b1);

        send(32'hFFFF_FFFF, 32'd1);
        finish_op(N, N, 1'b1);
        send(32'h8000_0000, 32'hFFFF_FFFF);
        finish_op(N, N, 1'b1);
        send(32'd3, 32'd10);
        finish_op(N, N, 1'b1);

        send(32'd5, 32'd0);
        finish_op(0, 0, 1'b1);
        send(32'd9, 32'd3);
        finish_op(N, N, 1'b1);

        // Start while busy: the 50/5 request must be ignored.
        send(32'd100, 32'd7);
        fork
            finish_op(N, N, 1'b1);
            begin
                repeat (10) @(negedge clk);
                dividend = 32'd50;
                divisor = 32'd5;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("hold_q", quotient == 32'd3, {32'd0, quotient}, 64'd3);
                chk("hold_r", remainder == 32'd0, {32'd0, remainder}, 64'd0);
            end
        join

        // Reset mid-operation.
        send(32'd1000, 32'd3);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", busy == 1'b0, {63'd0, busy}, 64'd0);
        chk("abort_q", quotient == '0, {32'd0, quotient}, 64'd0);
        chk("abort_r", remainder == '0, {32'd0, remainder}, 64'd0);
        chk("abort_dz", div_by_zero == 1'b0, {63'd0, div_by_zero}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", dcount == 0, 64'(dcount), 64'd0);
        send(32'hFFFF_FFFF, 32'h0001_0000);
        finish_op(N, N, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i % 97 == 5) rb = '0;
            send(ra, rb);
            finish_op(rb == 0 ? 0 : N, 0, 1'b0);
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size() == 0, 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
